// File: rtl/trace_arb_pkg.sv
// Shared constants, state encoding and helpers for the trace-line arbiter.
package trace_arb_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned SUM_W  = DROP_W + 1;

    localparam logic [CHAR_W-1:0] CH_START   = 8'h5E;
    localparam logic [CHAR_W-1:0] CH_END     = 8'h23;
    localparam logic [CHAR_W-1:0] ABORT_CHAR = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [CHAR_W-1:0] ch;
        logic              valid;
        logic              abort;
    } out_beat_t;

    // Saturating add of a 0..2 increment onto the drop counter.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] base,
                                                  input logic [1:0]        inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/trace_rr_pick.sv
// Two-way round-robin pick: on a tie the source that did not finish last wins.
module trace_rr_pick (
    input  logic cand0,
    input  logic cand1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = cand0 | cand1;
    assign gnt_idx   = (cand0 && cand1) ? ~last : cand1;

endmodule

// File: rtl/trace_line_arbiter.sv
// Line-granular round-robin arbiter feeding the trace-line checker.
// Optional line length cap enabled by defining LINE_LEN_LIMIT_EN.
module trace_line_arbiter
    import trace_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] src0_char,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [CHAR_W-1:0] src1_char,
    input  logic              src1_valid,
    output logic              src1_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_valid,
    output logic              out_src,
    output logic              line_abort,
    output logic [DROP_W-1:0] drop_cnt
);

    arb_state_e        state, state_d;
    logic              owner, owner_d;
    logic              last, last_d;
    logic [CNT_W-1:0]  stall, stall_d;
    out_beat_t         out_q, out_d;
    logic              out_src_d;
    logic [DROP_W-1:0] drop_d;

    logic              cand0, cand1, drop0, drop1;
    logic [1:0]        n_drop;
    logic              gnt_valid, gnt_idx;
    logic              own_valid;
    logic [CHAR_W-1:0] own_char;

`ifdef LINE_LEN_LIMIT_EN
    logic [CNT_W-1:0]  len, len_d;
    logic              len_hit;
    // len counts owner characters after '^', so len == MAX_LEN-2 means this one is the MAX_LEN-th.
    assign len_hit = (len == CNT_W'(MAX_LEN - 2)) && (own_char != CH_END);
`else
    logic              unused_max_len;
    assign unused_max_len = ^CNT_W'(MAX_LEN);
`endif

    assign cand0  = src0_valid && (src0_char == CH_START);
    assign cand1  = src1_valid && (src1_char == CH_START);
    assign drop0  = src0_valid && !cand0;
    assign drop1  = src1_valid && !cand1;
    assign n_drop = {1'b0, drop0} + {1'b0, drop1};

    assign own_valid = owner ? src1_valid : src0_valid;
    assign own_char  = owner ? src1_char  : src0_char;

    trace_rr_pick u_pick (
        .cand0     (cand0),
        .cand1     (cand1),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state, handshake and next-output logic.
    always_comb begin
        state_d    = state;
        owner_d    = owner;
        last_d     = last;
        stall_d    = stall;
        out_d      = '{ch: out_q.ch, valid: 1'b0, abort: 1'b0};
        out_src_d  = out_src;
        drop_d     = drop_cnt;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
`ifdef LINE_LEN_LIMIT_EN
        len_d      = len;
`endif
        case (state)
            IDLE: begin
                src0_ready = drop0 || (cand0 && !gnt_idx);
                src1_ready = drop1 || (cand1 && gnt_idx);
                drop_d     = sat_add(drop_cnt, n_drop);
                if (gnt_valid) begin
                    out_d.ch    = CH_START;
                    out_d.valid = 1'b1;
                    owner_d     = gnt_idx;
                    out_src_d   = gnt_idx;
                    stall_d     = '0;
                    state_d     = GRANT;
`ifdef LINE_LEN_LIMIT_EN
                    len_d       = '0;
`endif
                end
            end
            GRANT: begin
                src0_ready = !owner;
                src1_ready = owner;
                if (own_valid) begin
                    stall_d = '0;
`ifdef LINE_LEN_LIMIT_EN
                    len_d   = len + CNT_W'(1);
                    if (len_hit) state_d = ABORT;
                    else
`endif
                    begin
                        out_d.ch    = own_char;
                        out_d.valid = 1'b1;
                        if (own_char == CH_END) begin
                            last_d  = owner;
                            state_d = IDLE;
                        end
                    end
                end else if (stall == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                end else begin
                    stall_d = stall + CNT_W'(1);
                end
            end
            ABORT: begin
                out_d   = '{ch: ABORT_CHAR, valid: 1'b1, abort: 1'b1};
                last_d  = owner;
                stall_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            stall    <= '0;
            out_q    <= '0;
            out_src  <= 1'b0;
            drop_cnt <= '0;
`ifdef LINE_LEN_LIMIT_EN
            len      <= '0;
`endif
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            last     <= last_d;
            stall    <= stall_d;
            out_q    <= out_d;
            out_src  <= out_src_d;
            drop_cnt <= drop_d;
`ifdef LINE_LEN_LIMIT_EN
            len      <= len_d;
`endif
        end
    end

    assign out_char   = out_q.ch;
    assign out_valid  = out_q.valid;
    assign line_abort = out_q.abort;

endmodule

// File: doc/trace_line_arbiter.md
Name: trace_line_arbiter

Overview:
- Shares the single character input of the CPU trace-line checker between two trace producers (two cores or trace replay ports).
- Grants one complete line at a time, from '^' through '#', so lines from different sources are never interleaved.
- Round-robin between sources; mid-line stalls are aborted by timeout.
- Sits directly upstream of the checker's char port; the checker advances only on cycles where out_valid=1.

Parameters:
- TIMEOUT, 16, consecutive owner-stall cycles inside a granted line before abort (1..255).
- MAX_LEN, 64, maximum characters per line including '^' and '#'; used only with LINE_LEN_LIMIT_EN (2..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src0_char  in  8  source 0 ASCII character.
- src0_valid  in  1  source 0 character valid.
- src0_ready  out  1  source 0 character accepted this cycle (combinational).
- src1_char  in  8  source 1 ASCII character.
- src1_valid  in  1  source 1 character valid.
- src1_ready  out  1  source 1 character accepted this cycle (combinational).
- out_char  out  8  registered character to the checker.
- out_valid  out  1  out_char is valid this cycle.
- out_src  out  1  source index of the current or last granted line.
- line_abort  out  1  one-cycle pulse, aligned with ABORT_CHAR on out_char.
- drop_cnt  out  16  saturating count of discarded out-of-line characters.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out_char=8'h00; out_valid=0; out_src=0; line_abort=0; drop_cnt=0; stall=0; len=0.
  - last=1, so source 0 wins the first tie.
- Handshake: a character transfers when srcN_valid && srcN_ready. Every accepted character that is not dropped appears on out_char with out_valid=1 exactly one cycle later. When nothing transfers, out_valid=0.
- IDLE:
  - A source is a candidate when valid=1 and char=8'h5E ('^').
  - One candidate: it gets ready=1, its '^' is forwarded, owner<=N, out_src<=N, go to GRANT.
  - Two candidates: the winner is !last. The loser gets ready=0 and keeps its '^' pending.
  - A valid non-'^' character from any source gets ready=1 and is discarded with no output. drop_cnt increases by the number discarded this cycle (0, 1 or 2), saturating at 16'hFFFF.
- GRANT:
  - Owner ready=valid-independent 1. Non-owner ready=0; nothing from the non-owner is dropped.
  - Each accepted owner character is forwarded and clears stall to 0.
  - A '^' from the owner mid-line is forwarded and the grant is kept.
  - Accepted '#' (8'h23): forward it, last<=owner, go to IDLE. A new line can be granted in the very next cycle, so '#' followed by '^' can be back-to-back on the output.
  - Owner valid=0: stall increments. When stall reaches TIMEOUT-1 in a stalled cycle, go to ABORT.
- ABORT (one cycle):
  - Register out_char=8'h0A (ABORT_CHAR), out_valid=1, line_abort=1. This non-'^' character forces the checker back to its idle state.
  - Both ready=0; last<=owner; stall=0; go to IDLE.
- Reset asserted mid-line: immediate return to reset values; the partial line is never completed.

Optional Feature:
- Macro: LINE_LEN_LIMIT_EN.
- Defined:
  - len counts accepted characters of the granted line.
  - If a non-'#' character would be the MAX_LEN-th, it is accepted but not forwarded, and the next cycle is ABORT as above.
  - len clears on entering GRANT.
- Undefined: no length counter exists; lines of any length pass.

Decomposition:
- Package trace_arb_pkg:
  - Constants CH_START=8'h5E, CH_END=8'h23, ABORT_CHAR=8'h0A.
  - 2-bit state encodings IDLE/GRANT/ABORT.
  - Saturating-add width of 16.
- One sub-module, trace_rr_pick: combinational two-way round-robin pick (cand0, cand1, last -> gnt_valid, gnt_idx). Everything else lives in the top.

Test Plan:
- src0 sends "^10@00003000: $1 <= 0000000a#" with no stalls -> out_char is the identical stream delayed 1 cycle; out_src=0; src1_ready=0 throughout.
- Both sources present '^' in the same cycle right after reset -> src0 granted first. src1's line starts on the cycle after src0's '#' is accepted, and its '^' appears on out_char back-to-back with the '#'. A second simultaneous tie is won by src1.
- In IDLE, src1 sends "ab" then '^' -> drop_cnt=2; the '^' and the rest of the line are forwarded.
- src0 granted, stops valid after "^12@" for 16 cycles -> out_char=8'h0A with line_abort=1 for one cycle; state returns to IDLE; pending src1 '^' is granted next.
- With LINE_LEN_LIMIT_EN and MAX_LEN=8, src0 sends a 12-character line -> 7 characters forwarded, then 8'h0A with line_abort=1. Characters after the abort that are not '^' are dropped.
- Reset pulsed low mid-line -> all outputs zero asynchronously. After release, a new '^' from src1 is granted, since last=1 and src0 is idle.
